// File: rtl/uart_proto_pkg.sv
// uart_proto_pkg: shared FSM states, tag/abort defaults and grant encodings for the UART handler
package uart_proto_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_ABORT} state_t;
  localparam logic [7:0] ASC_TAG_DEF    = 8'h61;
  localparam logic [7:0] STL_TAG_DEF    = 8'h73;
  localparam logic [7:0] ABORT_BYTE_DEF = 8'h21;
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_ASC  = 2'b01;
  localparam logic [1:0] GRANT_STL  = 2'b10;
endpackage

// File: rtl/uart_response_arbiter_if.sv
// uart_response_arbiter_if: ASC/STL response streams, UART tx stream and arbiter status
interface uart_response_arbiter_if;
  logic       asc_valid, asc_ready, asc_last;
  logic [7:0] asc_data;
  logic       stl_valid, stl_ready, stl_last;
  logic [7:0] stl_data;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic [7:0] abort_count;
  modport master (
    input  asc_valid, asc_data, asc_last, stl_valid, stl_data, stl_last, tx_ready,
    output asc_ready, stl_ready, tx_valid, tx_data, grant, abort_count
  );
  modport slave (
    output asc_valid, asc_data, asc_last, stl_valid, stl_data, stl_last, tx_ready,
    input  asc_ready, stl_ready, tx_valid, tx_data, grant, abort_count
  );
endinterface

// File: rtl/uart_response_arbiter_stall_watchdog.sv
// stall_watchdog: saturating idle counter that flags a stalled packet source
module stall_watchdog #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] MAX = W'(TIMEOUT);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == MAX;
  always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_response_arbiter.sv
// uart_response_arbiter: round-robin, tag-prefixed packet mux of ASC/STL responses onto the UART tx path
module uart_response_arbiter
  import uart_proto_pkg::*;
#(
  parameter logic [7:0] ASC_TAG        = ASC_TAG_DEF,
  parameter logic [7:0] STL_TAG        = STL_TAG_DEF,
  parameter logic [7:0] ABORT_BYTE     = ABORT_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input logic clk,
  input logic n_reset,
  uart_response_arbiter_if.master bus
);
  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_stl_q, last_stl_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] abort_q, abort_d;
  logic       tx_free, sel_asc, src_valid, src_last, hs, pick_asc, expired;
  logic [7:0] src_data;
  assign tx_free   = !tx_valid_q || bus.tx_ready;
  assign sel_asc   = grant_q == GRANT_ASC;
  assign src_valid = sel_asc ? bus.asc_valid : bus.stl_valid;
  assign src_last  = sel_asc ? bus.asc_last : bus.stl_last;
  assign src_data  = sel_asc ? bus.asc_data : bus.stl_data;
  assign hs        = state_q == ST_DATA && tx_free && src_valid;
  // ties go to whichever source was not served last
  assign pick_asc  = bus.asc_valid && (!bus.stl_valid || last_stl_q);
  assign bus.asc_ready   = state_q == ST_DATA && sel_asc && tx_free;
  assign bus.stl_ready   = state_q == ST_DATA && grant_q == GRANT_STL && tx_free;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant       = grant_q;
  assign bus.abort_count = abort_q;
  stall_watchdog #(.TIMEOUT(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (state_q != ST_DATA || hs),
    .en      (state_q == ST_DATA && !src_valid),
    .expired (expired)
  );
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_stl_d = last_stl_q;
    tx_valid_d = tx_valid_q && !bus.tx_ready;
    tx_data_d  = tx_data_q;
    abort_d    = abort_q;
    case (state_q)
      ST_IDLE: if (bus.asc_valid || bus.stl_valid) begin
        grant_d = pick_asc ? GRANT_ASC : GRANT_STL;
        state_d = ST_HDR;
      end
      ST_HDR: if (tx_free) begin
        tx_valid_d = 1'b1;
        tx_data_d  = sel_asc ? ASC_TAG : STL_TAG;
        state_d    = ST_DATA;
      end
      ST_DATA: if (hs) begin
        tx_valid_d = 1'b1;
        tx_data_d  = src_data;
        if (src_last) begin
          state_d    = ST_IDLE;
          grant_d    = GRANT_NONE;
          last_stl_d = !sel_asc;
        end
      end else if (expired) state_d = ST_ABORT;
      ST_ABORT: if (tx_free) begin
        tx_valid_d = 1'b1;
        tx_data_d  = ABORT_BYTE;
        abort_d    = abort_q == 8'hff ? abort_q : abort_q + 8'd1;
        last_stl_d = !sel_asc;
        grant_d    = GRANT_NONE;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= GRANT_NONE;
      last_stl_q <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      abort_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_stl_q <= last_stl_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      abort_q    <= abort_d;
    end
endmodule
